// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: occupancy states and the
// default-width {ctrl, pc, data} entry layout used at stage boundaries.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   localparam int DEF_CTRL_W = 16;
   localparam int DEF_PC_W   = 18;
   localparam int DEF_DATA_W = 128;

   // Entry layout at the default widths; instances with other widths use
   // the same field order with their own parameters.
   typedef struct packed {
      logic [DEF_CTRL_W-1:0] ctrl;
      logic [DEF_PC_W-1:0]   pc;
      logic [DEF_DATA_W-1:0] data;
   } pipe_entry_t;

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush-to-bubble
// and a saturating counter of beats squashed by flush.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 16,
   parameter int PC_W   = 18,
   parameter int DATA_W = 128,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  drop_cnt
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] data;
   } entry_t;

   state_e            state_q, state_d;
   entry_t            head_q, head_d;
   entry_t            skid_q, skid_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   entry_t            in_entry;
   logic              push;
   logic              pop;
   logic [1:0]        drop_amt;
   logic [CNT_W+1:0]  drop_sum;

   // Ready depends only on registered state and reset, never on out_ready.
   assign in_ready  = !rst && (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign out_ctrl  = out_valid ? head_q.ctrl : '0;
   assign out_pc    = head_q.pc;
   assign out_data  = head_q.data;
   assign occupancy = state_q;
   assign drop_cnt  = drop_cnt_q;

   assign in_entry = '{ctrl: in_ctrl, pc: in_pc, data: in_data};
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;

   // A beat popped during flush was delivered, so it is not counted as dropped.
   assign drop_amt = occupancy - {1'b0, pop};
   assign drop_sum = {2'b00, drop_cnt_q} + {{CNT_W{1'b0}}, drop_amt};

   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      skid_d     = skid_q;
      drop_cnt_d = drop_cnt_q;

      if (flush) begin
         // Bubble keeps PC and payload; only valid and ctrl are cleared.
         state_d     = EMPTY;
         head_d.ctrl = '0;
         skid_d.ctrl = '0;
         if (drop_sum > {2'b00, {CNT_W{1'b1}}}) begin
            drop_cnt_d = '1;
         end else begin
            drop_cnt_d = drop_sum[CNT_W-1:0];
         end
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d = ONE;
                  head_d  = in_entry;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  state_d = TWO;
                  skid_d  = in_entry;
               end else if (pop && !push) begin
                  state_d = EMPTY;
               end else if (push && pop) begin
                  head_d = in_entry;
               end
            end
            TWO: begin
               if (pop) begin
                  state_d = ONE;
                  head_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule
